// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per two clocks, fed by a
// registered arctan ROM that is addressed one cycle ahead of its use.
module cordic_iter_engine #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int XW       = 16,
    parameter int ZW       = 16,
    parameter int N_ITER   = 12,
    parameter int ROM_BASE = 0
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_mode,
    input  logic [XW-1:0] in_x,
    input  logic [XW-1:0] in_y,
    input  logic [ZW-1:0] in_z,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] out_x,
    output logic [XW-1:0] out_y,
    output logic [ZW-1:0] out_z
);

    localparam int IW = $clog2(N_ITER + 1);

    typedef enum logic [1:0] {IDLE, WAIT, ROT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          i_q, i_d;
    logic                   mode_q, mode_d;
    logic signed [XW-1:0]   x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0]   z_q, z_d;
    logic [AW-1:0]          rom_addr_q, rom_addr_d;
    logic                   out_valid_q, out_valid_d;
    logic [XW-1:0]          out_x_q, out_x_d, out_y_q, out_y_d;
    logic [ZW-1:0]          out_z_q, out_z_d;

    logic                   d_pos;
    logic signed [XW-1:0]   x_sh, y_sh, x_rot, y_rot;
    logic signed [ZW-1:0]   atan_z, z_rot;

    // One micro-rotation from the current state; only committed in ROT.
    always_comb begin
        d_pos  = mode_q ? y_q[XW-1] : ~z_q[ZW-1];
        x_sh   = x_q >>> i_q;
        y_sh   = y_q >>> i_q;
        atan_z = {{(ZW-DW){1'b0}}, rom_data};
        x_rot  = d_pos ? (x_q - y_sh) : (x_q + y_sh);
        y_rot  = d_pos ? (y_q + x_sh) : (y_q - x_sh);
        z_rot  = d_pos ? (z_q - atan_z) : (z_q + atan_z);
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        mode_d      = mode_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        rom_addr_d  = rom_addr_q;
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_z_d     = out_z_q;
        case (state_q)
            IDLE: if (in_valid) begin
                mode_d     = in_mode;
                x_d        = in_x;
                y_d        = in_y;
                z_d        = in_z;
                i_d        = '0;
                rom_addr_d = AW'(ROM_BASE);
                state_d    = WAIT;
            end
            WAIT: state_d = ROT;
            ROT: begin
                x_d = x_rot;
                y_d = y_rot;
                z_d = z_rot;
                if (i_q == IW'(N_ITER - 1)) begin
                    out_x_d     = x_rot;
                    out_y_d     = y_rot;
                    out_z_d     = z_rot;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    // Prefetch next arctan so it lands on the next ROT edge.
                    i_d        = i_q + IW'(1);
                    rom_addr_d = AW'(ROM_BASE) + AW'(i_q) + AW'(1);
                    state_d    = WAIT;
                end
            end
            DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            i_q         <= '0;
            mode_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            rom_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_z_q     <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            mode_q      <= mode_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            rom_addr_q  <= rom_addr_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_z_q     <= out_z_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign rom_addr  = rom_addr_q;
    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_z     = out_z_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed bench: 12-iteration engine (ROM at 0x0100) against a golden model
// and rough trig values, plus a 1-iteration engine for hand-worked arithmetic.
module tb_cordic_iter_engine;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Angle LSB = 45/128 degree, so atan(1) = 128 fits the 8-bit ROM.
    logic [7:0] atan_tab [0:11] = '{8'd128, 8'd76, 8'd40, 8'd20, 8'd10, 8'd5,
                                    8'd3, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0};

    // 12-iteration instance (a_*)
    logic        a_in_valid = 0, a_in_ready, a_in_mode = 0, a_out_valid, a_out_ready = 0;
    logic [15:0] a_in_x = 0, a_in_y = 0, a_in_z = 0, a_rom_addr, a_out_x, a_out_y, a_out_z;
    logic [7:0]  a_rom_data = 0;

    // 1-iteration instance (b_*)
    logic        b_in_valid = 0, b_in_ready, b_in_mode = 0, b_out_valid, b_out_ready = 0;
    logic [15:0] b_in_x = 0, b_in_y = 0, b_in_z = 0, b_rom_addr, b_out_x, b_out_y, b_out_z;
    logic [7:0]  b_rom_data = 0;

    cordic_iter_engine #(.N_ITER(12), .ROM_BASE(16'h0100)) u_dut_a (
        .clk(clk), .rst_b(rst_b), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_mode(a_in_mode), .in_x(a_in_x), .in_y(a_in_y), .in_z(a_in_z),
        .rom_addr(a_rom_addr), .rom_data(a_rom_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_x(a_out_x), .out_y(a_out_y), .out_z(a_out_z));

    cordic_iter_engine #(.N_ITER(1), .ROM_BASE(0)) u_dut_b (
        .clk(clk), .rst_b(rst_b), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_mode(b_in_mode), .in_x(b_in_x), .in_y(b_in_y), .in_z(b_in_z),
        .rom_addr(b_rom_addr), .rom_data(b_rom_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_x(b_out_x), .out_y(b_out_y), .out_z(b_out_z));

    // Synchronous ROMs
    always_ff @(posedge clk) begin
        logic [15:0] off;
        off = a_rom_addr - 16'h0100;
        a_rom_data <= (off < 16'd12) ? atan_tab[off[3:0]] : 8'hEE;
        b_rom_data <= (b_rom_addr == 16'h0000) ? 8'h20 : 8'hEE;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_near(input string nm, input int act, input int exp, input int tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", nm, act, exp, tol);
        end
    endtask

    function automatic void golden(input logic mode, input logic signed [15:0] x0, y0, z0,
                                   output logic [15:0] xo, yo, zo);
        logic signed [15:0] x, y, z, xs, ys, a;
        logic pos;
        x = x0; y = y0; z = z0;
        for (int k = 0; k < 12; k++) begin
            pos = mode ? (y < 0) : (z >= 0);
            xs  = x >>> k;
            ys  = y >>> k;
            a   = {8'h00, atan_tab[k]};
            if (pos) begin x = x - ys; y = y + xs; z = z - a; end
            else     begin x = x + ys; y = y - xs; z = z + a; end
        end
        xo = x; yo = y; zo = z;
    endfunction

    task automatic start_a(input logic mode, input logic [15:0] x, y, z);
        @(negedge clk);
        chk("a_ready_before_job", a_in_ready, 1);
        a_in_mode = mode; a_in_x = x; a_in_y = y; a_in_z = z; a_in_valid = 1;
        @(posedge clk); #1;
        a_in_valid = 0;
    endtask

    task automatic wait_a(output int lat);
        lat = 0;
        while (!a_out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack_a();
        @(negedge clk); a_out_ready = 1;
        @(posedge clk); #1; a_out_ready = 0;
        chk("a_valid_drop", a_out_valid, 0);
    endtask

    typedef struct {
        logic        mode;
        logic [15:0] x, y, z;
        bit          approx;
        int          ax, ay;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [15:0] gx, gy, gz;
        int lat, seen;

        vecs[0] = '{0, 16'h26DD, 16'h0000, 16'h0055, 1, 14189,  8192};  // +30 deg
        vecs[1] = '{0, 16'h26DD, 16'h0000, 16'hFFAB, 1, 14189, -8192};  // -30 deg
        vecs[2] = '{0, 16'h26DD, 16'h0000, 16'h00FD, 1,   286, 16382};  // +89 deg
        vecs[3] = '{0, 16'h26DD, 16'h0000, 16'hFF03, 1,   286, -16382}; // -89 deg
        vecs[4] = '{0, 16'h26DD, 16'h0000, 16'h0000, 1, 16384,     0};
        vecs[5] = '{0, 16'h26DD, 16'h0000, 16'h8000, 0,     0,     0};  // wrap case
        vecs[6] = '{1, 16'h2000, 16'h2000, 16'h0000, 1, 19078,     0};  // vectoring 45 deg

        // Reset state, no clock edge yet
        #3;
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_rom_addr", a_rom_addr, 0);
        chk("rst_out_xyz", {a_out_x, a_out_y}, 0);
        @(negedge clk); rst_b = 1;

        // Address sequence and latency
        start_a(0, 16'h26DD, 16'h0000, 16'h0055);
        chk("addr_p0", a_rom_addr, 16'h0100);
        chk("busy_in_ready", a_in_ready, 0);
        for (int k = 1; k < 12; k++) begin
            @(posedge clk); #1;
            chk($sformatf("addr_hold_%0d", k), a_rom_addr, 16'h0100 + k - 1);
            @(posedge clk); #1;
            chk($sformatf("addr_step_%0d", k), a_rom_addr, 16'h0100 + k);
        end
        @(posedge clk); #1;
        chk("valid_not_early", a_out_valid, 0);
        @(posedge clk); #1;
        chk("valid_at_p24", a_out_valid, 1);
        chk("addr_after_final", a_rom_addr, 16'h010B);
        ack_a();

        // Table-driven full jobs
        for (int v = 0; v < 7; v++) begin
            golden(vecs[v].mode, vecs[v].x, vecs[v].y, vecs[v].z, gx, gy, gz);
            start_a(vecs[v].mode, vecs[v].x, vecs[v].y, vecs[v].z);
            wait_a(lat);
            chk($sformatf("v%0d_latency", v), lat, 24);
            chk($sformatf("v%0d_x", v), a_out_x, gx);
            chk($sformatf("v%0d_y", v), a_out_y, gy);
            chk($sformatf("v%0d_z", v), a_out_z, gz);
            if (vecs[v].approx) begin
                chk_near($sformatf("v%0d_x_trig", v), $signed(a_out_x), vecs[v].ax, 512);
                chk_near($sformatf("v%0d_y_trig", v), $signed(a_out_y), vecs[v].ay, 512);
            end
            ack_a();
            chk($sformatf("v%0d_x_kept", v), a_out_x, gx);
        end

        // Backpressure, ignored busy requests, back-to-back acceptance
        golden(0, 16'h26DD, 16'h0000, 16'h0055, gx, gy, gz);
        start_a(0, 16'h26DD, 16'h0000, 16'h0055);
        wait_a(lat);
        chk("bp_latency", lat, 24);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            a_in_valid = ~a_in_valid;
            a_in_x = 16'($urandom); a_in_z = 16'($urandom); a_in_mode = ~a_in_mode;
            @(posedge clk); #1;
            chk($sformatf("bp_valid_%0d", c), a_out_valid, 1);
            chk($sformatf("bp_in_ready_%0d", c), a_in_ready, 0);
            chk($sformatf("bp_xyz_%0d", c), {a_out_x, a_out_y}, {gx, gy});
            chk($sformatf("bp_addr_%0d", c), a_rom_addr, 16'h010B);
        end
        @(negedge clk);
        a_in_mode = 0; a_in_x = 16'h26DD; a_in_y = 0; a_in_z = 16'hFFAB;
        a_in_valid = 1; a_out_ready = 1;
        @(posedge clk); #1;
        a_out_ready = 0;
        chk("hs_valid_drop", a_out_valid, 0);
        chk("hs_in_ready_rise", a_in_ready, 1);
        chk("hs_out_kept", a_out_z, gz);
        @(posedge clk); #1;
        a_in_valid = 0;
        chk("b2b_accepted", a_in_ready, 0);
        chk("b2b_addr", a_rom_addr, 16'h0100);
        golden(0, 16'h26DD, 16'h0000, 16'hFFAB, gx, gy, gz);
        wait_a(lat);
        chk("b2b_latency", lat, 24);
        chk("b2b_xyz", {a_out_x, a_out_y, a_out_z}, {gx, gy, gz});
        ack_a();

        // Reset mid-job at iteration 5
        start_a(0, 16'h26DD, 16'h0000, 16'h00FD);
        repeat (11) @(posedge clk);
        #4; rst_b = 0; #1;
        chk("mid_rst_valid", a_out_valid, 0);
        chk("mid_rst_addr", a_rom_addr, 0);
        chk("mid_rst_out", {a_out_x, a_out_y, a_out_z}, 0);
        chk("mid_rst_ready", a_in_ready, 1);
        @(negedge clk); rst_b = 1;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (a_out_valid) seen++;
        end
        chk("aborted_never_valid", seen, 0);
        golden(0, 16'h26DD, 16'h0000, 16'h0055, gx, gy, gz);
        start_a(0, 16'h26DD, 16'h0000, 16'h0055);
        wait_a(lat);
        chk("post_rst_latency", lat, 24);
        chk("post_rst_xyz", {a_out_x, a_out_y, a_out_z}, {gx, gy, gz});
        ack_a();

        // Single iteration, rotation: d=+1
        @(negedge clk);
        b_in_mode = 0; b_in_x = 16'h1000; b_in_y = 16'h1000; b_in_z = 16'h0100; b_in_valid = 1;
        @(posedge clk); #1; b_in_valid = 0;
        chk("b_rot_addr", b_rom_addr, 0);
        @(posedge clk); #1;
        chk("b_rot_not_early", b_out_valid, 0);
        @(posedge clk); #1;
        chk("b_rot_valid", b_out_valid, 1);
        chk("b_rot_xyz", {b_out_x, b_out_y, b_out_z}, {16'h0000, 16'h2000, 16'h00E0});
        @(negedge clk); b_out_ready = 1;
        @(posedge clk); #1; b_out_ready = 0;
        chk("b_rot_drop", b_out_valid, 0);

        // Single iteration, vectoring with y<0: d=+1, x grows by |y|, y cancels
        @(negedge clk);
        b_in_mode = 1; b_in_x = 16'h1000; b_in_y = 16'hF000; b_in_z = 16'h0000; b_in_valid = 1;
        @(posedge clk); #1; b_in_valid = 0;
        repeat (2) begin @(posedge clk); #1; end
        chk("b_vec_valid", b_out_valid, 1);
        chk("b_vec_xyz", {b_out_x, b_out_y, b_out_z}, {16'h2000, 16'h0000, 16'hFFE0});
        @(negedge clk); b_out_ready = 1;
        @(posedge clk); #1; b_out_ready = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
